// File: rtl/signed_add_arbiter.sv
// signed_add_arbiter: round-robin arbiter sharing one registered signed adder
// among NUM_REQ requesters, with a one-entry backpressured result register.
// Build option: define SIGNED_ADD_ARB_SAT_EN to saturate sums to the DW-bit range.
module signed_add_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DW      = 8,
   parameter int unsigned IDW     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_vld,
   input  logic [NUM_REQ*DW-1:0] req_a,
   input  logic [NUM_REQ*DW-1:0] req_b,
   output logic [NUM_REQ-1:0]    req_rdy,
   output logic                  res_vld,
   output logic [DW:0]           res_data,
   output logic [IDW-1:0]        res_id,
   input  logic                  res_rdy,
   output logic [15:0]           acc_cnt
);

   logic           res_vld_q, res_vld_d;
   logic [DW:0]    res_data_q, res_data_d;
   logic [IDW-1:0] res_id_q, res_id_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [15:0]    acc_cnt_q, acc_cnt_d;

   logic           free;
   logic           gnt_found;
   logic [IDW-1:0] gnt_idx;
   logic           accept;
   logic [DW-1:0]  a_sel, b_sel;
   logic [DW:0]    sum_full, sum_res;

   // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      logic [IDW-1:0] idx;
      idx       = '0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!gnt_found && req_vld[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

   // Handshake: the output slot can take a new result when empty or draining.
   always_comb begin
      free    = ~res_vld_q | res_rdy;
      accept  = free & gnt_found & ~rst;
      req_rdy = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
   end

   // Full-precision adder on the granted operands, optional DW-bit saturation.
   always_comb begin
      a_sel    = req_a[gnt_idx*DW +: DW];
      b_sel    = req_b[gnt_idx*DW +: DW];
      sum_full = {a_sel[DW-1], a_sel} + {b_sel[DW-1], b_sel};
`ifdef SIGNED_ADD_ARB_SAT_EN
      // Top two bits disagree exactly when the sum leaves the DW-bit range.
      if (sum_full[DW] != sum_full[DW-1]) begin
         sum_res = sum_full[DW] ? {2'b11, {(DW-1){1'b0}}} : {2'b00, {(DW-1){1'b1}}};
      end else begin
         sum_res = sum_full;
      end
`else
      sum_res = sum_full;
`endif
   end

   // Next-state for the result register, pointer and acceptance counter.
   always_comb begin
      res_vld_d  = res_vld_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      rr_ptr_d   = rr_ptr_q;
      acc_cnt_d  = acc_cnt_q;
      if (accept) begin
         res_vld_d  = 1'b1;
         res_data_d = sum_res;
         res_id_d   = gnt_idx;
         rr_ptr_d   = (int'(gnt_idx) == int'(NUM_REQ) - 1) ? '0 : gnt_idx + 1'b1;
         acc_cnt_d  = acc_cnt_q + 16'd1;
      end else if (res_vld_q && res_rdy) begin
         res_vld_d = 1'b0;
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_vld_q  <= 1'b0;
         res_data_q <= '0;
         res_id_q   <= '0;
         rr_ptr_q   <= '0;
         acc_cnt_q  <= '0;
      end else begin
         res_vld_q  <= res_vld_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         rr_ptr_q   <= rr_ptr_d;
         acc_cnt_q  <= acc_cnt_d;
      end
   end

   assign res_vld  = res_vld_q;
   assign res_data = res_data_q;
   assign res_id   = res_id_q;
   assign acc_cnt  = acc_cnt_q;

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Directed testbench for signed_add_arbiter (NUM_REQ=4, DW=8, IDW=2).
module tb_signed_add_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned DW      = 8;
   localparam int unsigned IDW     = 2;

   logic                  clk;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_vld;
   logic [NUM_REQ*DW-1:0] req_a;
   logic [NUM_REQ*DW-1:0] req_b;
   logic [NUM_REQ-1:0]    req_rdy;
   logic                  res_vld;
   logic [DW:0]           res_data;
   logic [IDW-1:0]        res_id;
   logic                  res_rdy;
   logic [15:0]           acc_cnt;

   int n_vec;
   int n_err;

   signed_add_arbiter #(
      .NUM_REQ(NUM_REQ),
      .DW     (DW),
      .IDW    (IDW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_vld (req_vld),
      .req_a   (req_a),
      .req_b   (req_b),
      .req_rdy (req_rdy),
      .res_vld (res_vld),
      .res_data(res_data),
      .res_id  (res_id),
      .res_rdy (res_rdy),
      .acc_cnt (acc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst     = 1'b1;
      req_vld = 4'hF;
      req_a   = '0;
      req_b   = '0;
      res_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // Reset state, with requests pending.
      check("rst_res_vld", 32'(res_vld), 32'h0);
      check("rst_res_data", 32'(res_data), 32'h0);
      check("rst_res_id", 32'(res_id), 32'h0);
      check("rst_acc_cnt", 32'(acc_cnt), 32'h0);
      check("rst_req_rdy", 32'(req_rdy), 32'h0);
      rst     = 1'b0;
      req_vld = 4'h0;

      // Single requester 2: -128 + -128 = -256.
      set_op(2, 8'h80, 8'h80);
      req_vld = 4'b0100;
      #1;
      check("single_req_rdy", 32'(req_rdy), 32'h4);
      tick();
      req_vld = 4'h0;
      check("single_vld", 32'(res_vld), 32'h1);
      check("single_data", 32'(res_data), 32'h100);
      check("single_id", 32'(res_id), 32'h2);
      check("single_cnt", 32'(acc_cnt), 32'h1);
      tick();
      check("drain_vld", 32'(res_vld), 32'h0);
      check("drain_data_hold", 32'(res_data), 32'h100);

      // All four valid; pointer is at 3 after serving requester 2.
      for (int i = 0; i < 4; i++) set_op(i, 8'(i * 10 + 1), 8'(i));
      req_vld = 4'hF;
      for (int k = 0; k < 6; k++) begin
         int exp_id;
         exp_id = (3 + k) % 4;
         tick();
         check("rr_vld", 32'(res_vld), 32'h1);
         check("rr_id", 32'(res_id), 32'(exp_id));
         check("rr_data", 32'(res_data), 32'(exp_id * 11 + 1));
      end
      check("rr_cnt", 32'(acc_cnt), 32'd7);
      req_vld = 4'h0;
      tick();
      check("rr_drain", 32'(res_vld), 32'h0);

      // Backpressure: pointer at 1, requesters 1 and 3 pending.
      res_rdy = 1'b0;
      req_vld = 4'b1010;
      #1;
      check("bp_first_rdy", 32'(req_rdy), 32'h2);
      tick();
      req_vld = 4'b1000;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_req_rdy", 32'(req_rdy), 32'h0);
         check("bp_vld", 32'(res_vld), 32'h1);
         check("bp_id", 32'(res_id), 32'h1);
         check("bp_data", 32'(res_data), 32'd12);
         tick();
      end
      res_rdy = 1'b1;
      #1;
      check("bp_release_rdy", 32'(req_rdy), 32'h8);
      tick();
      req_vld = 4'h0;
      check("bp_next_id", 32'(res_id), 32'h3);
      check("bp_next_data", 32'(res_data), 32'd34);
      check("bp_cnt", 32'(acc_cnt), 32'd9);

      // Fairness: requester 0 continuous, requester 2 joins later.
      req_vld = 4'b0001;
      tick();
      check("fair_id0", 32'(res_id), 32'h0);
      tick();
      check("fair_id0_skip", 32'(res_id), 32'h0);
      req_vld = 4'b0101;
      tick();
      check("fair_id2", 32'(res_id), 32'h2);
      check("fair_data2", 32'(res_data), 32'd23);
      tick();
      check("fair_back0", 32'(res_id), 32'h0);
      check("fair_cnt", 32'(acc_cnt), 32'd13);
      req_vld = 4'h0;

      // Range boundaries on requester 1.
      req_vld = 4'b0010;
      set_op(1, 8'd127, 8'd1);
      tick();
`ifdef SIGNED_ADD_ARB_SAT_EN
      check("ovf_127p1", 32'(res_data), 32'h07F);
`else
      check("ovf_127p1", 32'(res_data), 32'h080);
`endif
      set_op(1, 8'd100, 8'd100);
      tick();
`ifdef SIGNED_ADD_ARB_SAT_EN
      check("ovf_100p100", 32'(res_data), 32'h07F);
`else
      check("ovf_100p100", 32'(res_data), 32'h0C8);
`endif
      set_op(1, 8'h80, 8'hFF);
      tick();
`ifdef SIGNED_ADD_ARB_SAT_EN
      check("ovf_m128m1", 32'(res_data), 32'h180);
`else
      check("ovf_m128m1", 32'(res_data), 32'h17F);
`endif
      check("ovf_cnt", 32'(acc_cnt), 32'd16);

      // Asynchronous reset mid-stream with a valid result held.
      req_vld = 4'b0001;
      #2;
      rst = 1'b1;
      #1;
      check("arst_vld", 32'(res_vld), 32'h0);
      check("arst_cnt", 32'(acc_cnt), 32'h0);
      check("arst_req_rdy", 32'(req_rdy), 32'h0);
      check("arst_data", 32'(res_data), 32'h0);
      tick();
      rst = 1'b0;

      // Counter wrap.
      repeat (65535) tick();
      check("wrap_ffff", 32'(acc_cnt), 32'hFFFF);
      tick();
      check("wrap_zero", 32'(acc_cnt), 32'h0);
      req_vld = 4'h0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/signed_add_arbiter.md
# signed_add_arbiter

Round-robin arbiter and sequencer that shares one registered signed adder among NUM_REQ requesters. Each requester presents a signed operand pair with a valid/ready handshake. The block grants one request per cycle, computes the full-precision signed sum, and presents it on a single backpressured result port. The result is tagged with the requester index. It sits between several producer blocks and the downstream consumer of signed sums, replacing per-producer adders.

## Interface
- NUM_REQ, 4: number of requesters, legal range 2..8.
- DW, 8: operand width, two's complement.
- IDW, 2: requester-index width; must be ≥ clog2(NUM_REQ).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high; one clock, asynchronous active-high reset.
- req_vld  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*DW  packed signed operand A; requester i at bits [i*DW +: DW].
- req_b  in  NUM_REQ*DW  packed signed operand B, same packing.
- req_rdy  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- res_vld  out  1  result valid.
- res_data  out  DW+1  signed sum.
- res_id  out  IDW  index of the requester that produced res_data.
- res_rdy  in  1  downstream accepts result.
- acc_cnt  out  16  count of accepted requests; wraps 0xFFFF→0x0000.

## Operation
- Output stage: one-entry register holding res_vld, res_data and res_id. It is "free" when res_vld=0 or res_rdy=1.
- Arbitration is combinational from req_vld, the round-robin pointer rr_ptr and free.
  - grant = first i with req_vld[i]=1, searching from index rr_ptr upward and wrapping modulo NUM_REQ.
  - req_rdy = one-hot grant when free=1, else all zero.
- Acceptance is the transfer req_vld[i] & req_rdy[i]. On acceptance:
  - res_data ← sign-extend(a_i, DW+1) + sign-extend(b_i, DW+1).
  - res_id ← i.
  - res_vld ← 1.
  - rr_ptr ← (i+1) mod NUM_REQ.
  - acc_cnt ← acc_cnt+1.
- No acceptance and res_vld & res_rdy: res_vld ← 0. res_data and res_id hold their stale value.
- rr_ptr changes only on acceptance, so a requester that is not served keeps its position.
- Arithmetic: full precision, no overflow possible in DW+1 bits. The range is −2^DW .. 2^DW−2.
- Requesters must hold req_vld, req_a and req_b stable until accepted. A dropped req_vld before acceptance means the request is withdrawn, with no side effect.
- Reset is asserted asynchronously and released synchronously by the system. The block cares only about the value held while rst=1. Reset mid-operation discards the held result and any pending grant.

## Timing
- Reset values: res_vld=0, res_data=0, res_id=0, rr_ptr=0, acc_cnt=0. req_rdy=0 while rst=1.
- Latency: an acceptance in cycle N gives res_vld=1 with the result in cycle N+1.
- Throughput: one result per cycle while res_rdy=1 and any req_vld=1.
- Simultaneous drain and fill in the same cycle: the new result replaces the drained one with no bubble, and res_vld stays 1.
- res_rdy=0 with res_vld=1 is a stall: req_rdy=0 and the output holds all fields stable.
- req_rdy depends combinationally on req_vld and res_rdy. There is no combinational path from req_a or req_b to any output.

## Configuration
- SIGNED_ADD_ARB_SAT_EN defined:
  - res_data is saturated to the DW-bit range [−2^(DW−1), 2^(DW−1)−1] and then sign-extended to DW+1 bits.
  - For DW=8, 100+100 gives 127 and −128+−1 gives −128.
  - Latency is unchanged.
- SIGNED_ADD_ARB_SAT_EN not defined: full-precision DW+1 result as above.

## Test plan
- Reset check: assert rst mid-stream with res_vld=1 → res_vld=0, acc_cnt=0, req_rdy=0 immediately, without waiting for a clock edge.
- Single requester 2 with a=−128, b=−128, res_rdy=1 → one cycle later res_vld=1, res_data=−256 (9'h100), res_id=2, acc_cnt=1.
- All four requesters valid continuously, res_rdy=1 → grants in order 0,1,2,3,0,…, one per cycle, each res_id matching and no gaps.
- Backpressure: res_rdy=0 for 5 cycles with requesters 1 and 3 pending → req_rdy=0 and output frozen. After release, 1 is served, then 3.
- Fairness: requester 0 asserts continuously and requester 2 asserts at cycle 3 → requester 2 is granted within NUM_REQ cycles, and rr_ptr skips idle indices.
- Counter wrap and saturation:
  - Preload 65535 accepts (or force acc_cnt) → the next accept gives acc_cnt=0.
  - With SIGNED_ADD_ARB_SAT_EN, 127+1 → res_data=127.
  - Without the macro, 127+1 → res_data=128.
